// File: rtl/io_scff_bank_if.sv
// Port bundle for io_scff_bank: functional data, scan chain and serial configuration.
// Carries par_o only when IO_SCFF_PARITY_EN is defined.
interface io_scff_bank_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] d_i;
    logic             ce_i;
    logic             srst_i;
    logic             se_i;
    logic             si_i;
    logic             so_o;
    logic             scan_done_o;
    logic             cfg_en_i;
    logic             cfg_d_i;
    logic             cfg_q_o;
    logic [WIDTH-1:0] q_o;
`ifdef IO_SCFF_PARITY_EN
    logic             par_o;
`endif

    modport master (
        output d_i, ce_i, srst_i, se_i, si_i, cfg_en_i, cfg_d_i,
        input  so_o, scan_done_o, cfg_q_o, q_o
`ifdef IO_SCFF_PARITY_EN
        , input par_o
`endif
    );

    modport slave (
        input  d_i, ce_i, srst_i, se_i, si_i, cfg_en_i, cfg_d_i,
        output so_o, scan_done_o, cfg_q_o, q_o
`ifdef IO_SCFF_PARITY_EN
        , output par_o
`endif
    );
endinterface

// File: rtl/io_scff_bank.sv
// WIDTH-bit multi-mode IO scan flop bank with serial mode configuration and scan-length counting.
// Optional registered parity output enabled by defining IO_SCFF_PARITY_EN.
module io_scff_bank #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 6
) (
    input  logic          clk_i,
    input  logic          clr_i,
    io_scff_bank_if.slave bus
);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_next;
    logic [WIDTH:0]   shift_ext;
    logic [3:0]       cfg;
    logic [2:0]       mode;
    logic             inv;
    logic             use_reg;
    logic [CNT_W-1:0] scan_cnt;
    logic             scan_done;

    assign mode      = cfg[2:0];
    assign inv       = cfg[3];
    assign use_reg   = (mode == 3'd1) || (mode == 3'd2) || (mode == 3'd3);
    // Extending by one bit keeps the shift expression valid for WIDTH=1.
    assign shift_ext = {data_q, bus.si_i};

    // NOTE: data_next is defaulted on entry so every path assigns it and no latch is inferred.
    always_comb begin
        data_next = bus.d_i;
        if (bus.se_i) begin
            data_next = shift_ext[WIDTH-1:0];
        end else begin
            case (mode)
                3'd2:    if (!bus.ce_i) data_next = data_q;
                3'd3:    if (bus.srst_i) data_next = '0;
                default: data_next = bus.d_i;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops sample pre-edge values together.
    always_ff @(posedge clk_i or posedge clr_i) begin
        if (clr_i) begin
            data_q    <= '0;
            cfg       <= 4'b0000;
            scan_cnt  <= '0;
            scan_done <= 1'b0;
        end else begin
            data_q <= data_next;
            if (bus.cfg_en_i) cfg <= {cfg[2:0], bus.cfg_d_i};
            if (!bus.se_i) begin
                scan_cnt  <= '0;
                scan_done <= 1'b0;
            end else if (scan_cnt == LAST_CNT) begin
                scan_cnt  <= '0;
                scan_done <= 1'b1;
            end else begin
                scan_cnt  <= scan_cnt + CNT_W'(1);
                scan_done <= 1'b0;
            end
        end
    end

    // Inversion touches only the functional output, never the scan path.
    assign bus.q_o         = (use_reg ? data_q : bus.d_i) ^ {WIDTH{inv}};
    assign bus.so_o        = data_q[WIDTH-1];
    assign bus.scan_done_o = scan_done;
    assign bus.cfg_q_o     = cfg[3];

`ifdef IO_SCFF_PARITY_EN
    logic par_q;

    always_ff @(posedge clk_i or posedge clr_i) begin
        if (clr_i) par_q <= 1'b0;
        else       par_q <= ^data_next;
    end

    assign bus.par_o = par_q;
`endif
endmodule

// File: tb/tb_io_scff_bank.sv
// Self-checking bench for io_scff_bank (WIDTH=4): arithmetic reference model plus directed literal checks.
// Define IO_SCFF_PARITY_EN to also exercise par_o.
module tb_io_scff_bank;
    localparam int WIDTH = 4;
    localparam int CNT_W = 6;
    localparam int SPAN  = 1 << WIDTH;

    logic clk_i;
    logic clr_i;
    bit   chk_en;
    int   checks;
    int   errors;

    io_scff_bank_if #(.WIDTH(WIDTH)) bus ();

    io_scff_bank #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk_i (clk_i),
        .clr_i (clr_i),
        .bus   (bus.slave)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference state as plain integers: data as a number, config as a number, shifts since se rose.
    int m_data;
    int m_cfg;
    int m_shifts;
    bit m_done;
    int m_mode;
    int m_next;

    always @(posedge clk_i or posedge clr_i) begin
        if (clr_i) begin
            m_data   = 0;
            m_cfg    = 0;
            m_shifts = 0;
            m_done   = 1'b0;
        end else begin
            m_mode = m_cfg % 8;
            if (bus.se_i)                       m_next = (m_data * 2 + int'(bus.si_i)) % SPAN;
            else if (m_mode == 2 && !bus.ce_i)  m_next = m_data;
            else if (m_mode == 3 && bus.srst_i) m_next = 0;
            else                                m_next = int'(bus.d_i);
            if (bus.se_i) begin
                m_shifts = m_shifts + 1;
                m_done   = (m_shifts % WIDTH) == 0;
            end else begin
                m_shifts = 0;
                m_done   = 1'b0;
            end
            if (bus.cfg_en_i) m_cfg = (m_cfg * 2 + int'(bus.cfg_d_i)) % 16;
            m_data = m_next;
        end
    end

    function automatic int exp_q();
        int md;
        int base;
        md   = m_cfg % 8;
        base = (md >= 1 && md <= 3) ? m_data : int'(bus.d_i);
        return (m_cfg >= 8) ? (SPAN - 1 - base) : base;
    endfunction

    always @(negedge clk_i) begin
        if (chk_en && !clr_i) begin
            check("m_q",      32'(bus.q_o),         32'(exp_q()));
            check("m_so",     32'(bus.so_o),        32'(m_data / (SPAN / 2)));
            check("m_done",   32'(bus.scan_done_o), 32'(m_done));
            check("m_cfg_q",  32'(bus.cfg_q_o),     32'(m_cfg / 8));
`ifdef IO_SCFF_PARITY_EN
            check("m_par",    32'(bus.par_o),       32'($countones(m_data) % 2));
`endif
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic load_cfg(input logic [3:0] v);
        for (int i = 3; i >= 0; i--) begin
            bus.cfg_en_i = 1'b1;
            bus.cfg_d_i  = v[i];
            tick();
        end
        bus.cfg_en_i = 1'b0;
        bus.cfg_d_i  = 1'b0;
    endtask

    initial begin
        logic [3:0] bits;
        logic [3:0] so_seq;
        checks = 0;
        errors = 0;
        chk_en = 1'b0;
        clr_i  = 1'b0;
        bus.d_i = '0; bus.ce_i = 1'b0; bus.srst_i = 1'b0; bus.se_i = 1'b0;
        bus.si_i = 1'b0; bus.cfg_en_i = 1'b0; bus.cfg_d_i = 1'b0;

        #2 clr_i = 1'b1;
        #1;
        check("rst_q", 32'(bus.q_o), 32'h0);
        check("rst_so", 32'(bus.so_o), 32'h0);
        repeat (2) @(posedge clk_i);
        #1 clr_i = 1'b0;
        chk_en = 1'b1;

        // Scan works in mode 0: shift four ones in.
        bus.se_i = 1'b1; bus.si_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("m0_scan_so", 32'(bus.so_o), 32'h0);
            tick();
        end
        check("m0_scan_so_end", 32'(bus.so_o), 32'h1);
        check("m0_scan_done", 32'(bus.scan_done_o), 32'h1);
        bus.se_i = 1'b0; bus.d_i = 4'h6;
        #1 check("m0_q_comb", 32'(bus.q_o), 32'h6);
        tick();
        check("m0_done_clear", 32'(bus.scan_done_o), 32'h0);

        // Asynchronous reset mid-cycle.
        #2 bus.d_i = 4'hA; clr_i = 1'b1;
        #1;
        check("clr_q", 32'(bus.q_o), 32'hA);
        check("clr_so", 32'(bus.so_o), 32'h0);
        check("clr_done", 32'(bus.scan_done_o), 32'h0);
        check("clr_cfg_q", 32'(bus.cfg_q_o), 32'h0);
        tick();
        clr_i = 1'b0;

        // Mode 1, no inversion.
        load_cfg(4'b0001);
        bus.d_i = 4'h5;
        tick();
        check("m1_q5", 32'(bus.q_o), 32'h5);
        bus.d_i = 4'h3;
        #1 check("m1_latency", 32'(bus.q_o), 32'h5);
        tick();
        check("m1_q3", 32'(bus.q_o), 32'h3);

        // Reload with inv=1; prior config 0001 streams out of cfg_q_o.
        bits   = 4'b1001;
        so_seq = 4'b0001;
        for (int i = 3; i >= 0; i--) begin
            bus.cfg_en_i = 1'b1;
            bus.cfg_d_i  = bits[i];
            check("cfg_q_seq", 32'(bus.cfg_q_o), 32'(so_seq[i]));
            tick();
        end
        bus.cfg_en_i = 1'b0;
        check("m1_inv_q", 32'(bus.q_o), 32'hC);

        // Mode 2 clock enable.
        load_cfg(4'b0010);
        bus.d_i = 4'hF; bus.ce_i = 1'b0;
        tick();
        check("m2_hold", 32'(bus.q_o), 32'h3);
        bus.ce_i = 1'b1;
        tick();
        check("m2_load", 32'(bus.q_o), 32'hF);
        bus.ce_i = 1'b0;

        // Mode 3 synchronous reset, and scan beating it.
        load_cfg(4'b0011);
        bus.srst_i = 1'b1;
        tick();
        check("m3_srst", 32'(bus.q_o), 32'h0);
        bus.se_i = 1'b1; bus.si_i = 1'b1;
        tick();
        check("m3_scan_wins", 32'(bus.q_o), 32'h1);
        bus.se_i = 1'b0; bus.srst_i = 1'b0; bus.d_i = 4'h9;
        tick();
        check("m3_load9", 32'(bus.q_o), 32'h9);

        // Full scan burst from 4'h9 with si = 1,0,1,1.
        bits   = 4'b1011;
        so_seq = 4'b1001;
        bus.se_i = 1'b1;
        for (int i = 3; i >= 0; i--) begin
            bus.si_i = bits[i];
            check("scan_so_seq", 32'(bus.so_o), 32'(so_seq[i]));
            check("scan_done_low", 32'(bus.scan_done_o), 32'h0);
            tick();
        end
        check("scan_done_pulse", 32'(bus.scan_done_o), 32'h1);
        check("scan_final", 32'(bus.q_o), 32'hB);
        bus.se_i = 1'b0;
        tick();
        check("scan_done_once", 32'(bus.scan_done_o), 32'h0);

        // Partial burst of 3 is discarded; the following burst of 4 pulses once.
        bus.se_i = 1'b1; bus.si_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("partial_no_done", 32'(bus.scan_done_o), 32'h0);
        end
        bus.se_i = 1'b0;
        tick();
        check("partial_gap", 32'(bus.scan_done_o), 32'h0);
        bus.se_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("burst2_done", 32'(bus.scan_done_o), (i == 3) ? 32'h1 : 32'h0);
        end
        bus.se_i = 1'b0;
        tick();
        check("burst2_clear", 32'(bus.scan_done_o), 32'h0);

`ifdef IO_SCFF_PARITY_EN
        load_cfg(4'b0001);
        bus.d_i = 4'h7;
        tick();
        check("par_7", 32'(bus.par_o), 32'h1);
        bus.d_i = 4'h3;
        tick();
        check("par_3", 32'(bus.par_o), 32'h0);
        bus.d_i = 4'h7;
        tick();
        #2 clr_i = 1'b1;
        #1 check("par_clr", 32'(bus.par_o), 32'h0);
        tick();
        clr_i = 1'b0;
`endif

        repeat (2) tick();
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
